ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 46 ++++
 rtl/ram_arbiter_if.sv | 70 +++++++
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter.
// Bus widths, control encodings, FSM states and the latched access bundle.
package ram_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam data_t ZERO_WORD     = '0;
    localparam logic  CHIP_ENABLE   = 1'b1;
    localparam logic  CHIP_DISABLE  = 1'b0;
    localparam logic  WRITE_ENABLE  = 1'b1;
    localparam logic  WRITE_DISABLE = 1'b0;
    localparam logic  RST_ENABLE    = 1'b1;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    typedef enum logic {
        WIN_IF  = 1'b0,
        WIN_MEM = 1'b1
    } win_t;

    typedef struct packed {
        win_t       id;
        logic       we;
        logic [3:0] sel;
        addr_t      addr;
        data_t      wdata;
    } acc_t;

    localparam acc_t ACC_NONE = '{
        id:    WIN_IF,
        we:    WRITE_DISABLE,
        sel:   4'b0000,
        addr:  '0,
        wdata: '0
    };

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM port bundle for the arbiter.
// master is the arbiter side, slave is the core/RAM side.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic       if_req;
    addr_t      if_addr;
    data_t      if_rdata;
    logic       if_done;

    logic       mem_req;
    logic       mem_we;
    addr_t      mem_addr;
    logic [3:0] mem_sel;
    data_t      mem_wdata;
    data_t      mem_rdata;
    logic       mem_done;

    logic       ram_ce;
    logic       ram_we;
    addr_t      ram_addr;
    logic [3:0] ram_sel;
    data_t      ram_wdata;
    data_t      ram_rdata;

    logic       stall_req;

    modport master (
        input  if_req,
        input  if_addr,
        output if_rdata,
        output if_done,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_sel,
        input  mem_wdata,
        output mem_rdata,
        output mem_done,
        output ram_ce,
        output ram_we,
        output ram_addr,
        output ram_sel,
        output ram_wdata,
        input  ram_rdata,
        output stall_req
    );

    modport slave (
        output if_req,
        output if_addr,
        input  if_rdata,
        input  if_done,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_sel,
        output mem_wdata,
        input  mem_rdata,
        input  mem_done,
        input  ram_ce,
        input  ram_we,
        input  ram_addr,
        input  ram_sel,
        input  ram_wdata,
        output ram_rdata,
        input  stall_req
    );

endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter (instruction fetch vs load/store) for one RAM port.
// One access per IDLE->ACC pair; MEM has priority unless IF is starving.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.master bus
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nx;
    acc_t          lat;
    acc_t          lat_nx;

    logic  if_elig;
    logic  mem_elig;
    logic  grant_if;
    logic  grant_mem;
    logic  in_acc;

    logic  if_done;
    logic  mem_done;
    data_t if_rdata;
    data_t mem_rdata;

    assign in_acc = (state == ST_ACC);

    // Eligibility and winner selection; a requester in its done cycle still
    // holds req, so it must sit out that contest.
    always_comb begin
        if_elig   = bus.if_req & ~if_done;
        mem_elig  = bus.mem_req & ~mem_done;
        grant_mem = mem_elig & ~(if_elig & (streak == LIMIT));
        grant_if  = if_elig & ~grant_mem;
    end

    // Next state, streak and latched access; ACC always returns to IDLE.
    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        lat_nx    = lat;
        unique case (state)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_nx = ST_ACC;
                    lat_nx   = '{
                        id:    WIN_MEM,
                        we:    bus.mem_we,
                        sel:   bus.mem_sel,
                        addr:  bus.mem_addr,
                        wdata: bus.mem_wdata
                    };
                    if (if_elig) begin
                        if (streak == LIMIT) begin
                            streak_nx = LIMIT;
                        end else begin
                            streak_nx = streak + 1'b1;
                        end
                    end else begin
                        streak_nx = '0;
                    end
                end else if (grant_if) begin
                    state_nx  = ST_ACC;
                    streak_nx = '0;
                    lat_nx    = '{
                        id:    WIN_IF,
                        we:    WRITE_DISABLE,
                        sel:   SEL_ALL,
                        addr:  bus.if_addr,
                        wdata: ZERO_WORD
                    };
                end
            end
            ST_ACC: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, streak, done pulses and read-data capture at the end of ACC.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_IDLE;
            streak    <= '0;
            lat       <= ACC_NONE;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= ZERO_WORD;
            mem_rdata <= ZERO_WORD;
        end else begin
            state    <= state_nx;
            streak   <= streak_nx;
            lat      <= lat_nx;
            if_done  <= in_acc && (lat.id == WIN_IF);
            mem_done <= in_acc && (lat.id == WIN_MEM);
            if (in_acc && (lat.we == WRITE_DISABLE)) begin
                if (lat.id == WIN_IF) begin
                    if_rdata <= bus.ram_rdata;
                end else begin
                    mem_rdata <= bus.ram_rdata;
                end
            end
        end
    end

    // RAM port: latched fields during ACC, quiet otherwise; reset kills ce.
    always_comb begin
        bus.ram_ce    = CHIP_DISABLE;
        bus.ram_we    = WRITE_DISABLE;
        bus.ram_addr  = '0;
        bus.ram_sel   = 4'b0000;
        bus.ram_wdata = ZERO_WORD;
        if (in_acc) begin
            bus.ram_ce    = (rst == RST_ENABLE) ? CHIP_DISABLE : CHIP_ENABLE;
            bus.ram_we    = lat.we;
            bus.ram_addr  = lat.addr;
            bus.ram_sel   = lat.sel;
            bus.ram_wdata = lat.wdata;
        end
    end

    assign bus.if_done   = if_done;
    assign bus.mem_done  = mem_done;
    assign bus.if_rdata  = if_rdata;
    assign bus.mem_rdata = mem_rdata;

    assign bus.stall_req = (bus.if_req & ~if_done)
                         | (bus.mem_req & ~mem_done);

endmodule
